dvp_tx: RTL and testbench
=========================

# dvp_tx

Camera-side DVP transmitter: reads 12-bit RGB444 pixels from a FIFO and emits OV7670-style frames on vsync/href/8-bit data, two bytes per pixel. It is the counterpart of `capture`. It serves as a sensor emulator for loopback of the capture path and as an output stage toward DVP-input devices. All outputs are registered and change on the rising edge of `i_clk`.

## Interface
Parameters:
- COLS, 10: pixels per row; href is high for 2*COLS cycles.
- ROWS, 5: rows per frame.
- VSYNC_LEN, 3: vsync pulse width in cycles.
- VBP, 17: cycles from vsync fall to the first possible row start.
- HBLANK, 5: minimum href-low cycles between rows.
- VFP, 10: cycles after the last row before `o_frame_done` is asserted.

Ports:
- i_clk  in  1  pixel clock; the only clock.
- i_rst  in  1  synchronous, active-high reset.
- i_en  in  1  frame enable, sampled in IDLE and at frame end.
- o_rd  out  1  FIFO read strobe.
- i_rdata  in  12  FIFO data, valid the cycle after `o_rd` (standard one-cycle-latency FIFO).
- i_empty  in  1  FIFO empty.
- o_vsync  out  1  frame sync, active high.
- o_href  out  1  line valid.
- o_data  out  8  pixel byte.
- o_underflow  out  1  one-cycle pulse when a pixel is substituted.
- o_frame_done  out  1  one-cycle pulse at the end of VFP.

## Operation
- States: IDLE, VSYNC, VBP, HBLANK, ROW, VFP.
- IDLE:
  - All outputs are low.
  - When `i_en`=1, go to VSYNC.
- VSYNC: `o_vsync`=1 for VSYNC_LEN cycles, then go to VBP.
- VBP then HBLANK (row gating):
  - Wait the programmed count (VBP, or HBLANK between rows).
  - After the count, the block issues the first `o_rd` of the row only in a cycle with `i_empty`=0.
  - While the FIFO is empty the blanking is extended indefinitely. There is no underflow at row start.
- ROW: each pixel occupies two cycles.
  - Byte 0 = {PAD_NIBBLE, pix[11:8]}.
  - Byte 1 = pix[7:4], pix[3:0].
- Next-pixel fetch:
  - The read for the next pixel is issued during byte 0 of the current pixel.
  - If `i_empty`=1 at that point, no read is issued. The next pixel is sent as UNDERFLOW_PIX (12'h000) and `o_underflow` pulses during its byte-0 cycle.
  - href is never stalled mid-row.
- After 2*COLS bytes:
  - `o_href` falls.
  - If the row counter < ROWS-1, go to HBLANK; otherwise go to VFP.
- VFP: after VFP cycles, `o_frame_done` pulses. Then:
  - `i_en`=1: go to VSYNC (next frame).
  - `i_en`=0: go to IDLE.
- Deasserting `i_en` mid-frame has no effect until the frame ends; frames are always complete.
- Counters: row and column counters are 16-bit and clear at frame start. `o_data` is 0 whenever `o_href`=0.

## Timing
- Reset:
  - Next edge: state=IDLE.
  - All outputs 0: `o_vsync`, `o_href`, `o_data`, `o_rd`, `o_underflow`, `o_frame_done`.
  - Counters are cleared and the pixel register is 0.
  - Reset mid-row truncates the row immediately; no partial FIFO state is retained.
- Row start: with `o_rd` high in cycle T:
  - `i_rdata` is latched in T+1.
  - `o_href` rises with byte 0 in T+2; byte 1 follows in T+3.
- Steady state: `o_rd` is high in cycles T+2, T+4, and so on (byte-0 cycles), for pixels 1..COLS-1 only.
- Reads per row:
  - Exactly COLS reads when there is no underflow.
  - No read is issued for the last pixel's successor.
- Frame period, no stalls: VSYNC_LEN + VBP + 2 + ROWS*2*COLS + (ROWS-1)*(HBLANK+2) + VFP cycles. Each row start includes 2 fetch cycles.
- Simultaneous events:
  - `i_empty` rising in the same cycle as a due read: the read is skipped (the empty flag is sampled that cycle).
  - `i_en` falling in the `o_frame_done` cycle: go to IDLE.

## Configuration
- `DVP_TX_TESTPAT_EN` defined:
  - Adds input port `i_testpat` (1 bit), sampled at VSYNC entry.
  - If set, that frame uses the internal pattern pix = {row[3:0], col[7:0]}.
  - In pattern mode, `o_rd` stays 0, `i_empty` is ignored, and there is no underflow or row-start gating.
- Undefined: the port and pattern logic are absent and the block is FIFO-only.

## Structure
- Package `dvp_pkg` holds:
  - the state enum `dvp_tx_state_t`;
  - `PAD_NIBBLE` = 4'h0;
  - `UNDERFLOW_PIX` = 12'h000;
  - counter width `DVP_CNT_W` = 16.
- One natural sub-module, `dvp_tx_timing`:
  - contains the state machine and the blank/row/column counters;
  - outputs byte phase, row start, and end-of-frame strobes.
- The top level handles fetch, the pixel register, byte muxing, and the output registers.

## Test plan
- Loopback: FIFO preloaded with 50 random pixels, default parameters, output fed to `capture` -> 50 `o_wr` with identical `o_wdata` in order; exactly 50 `o_rd`; `o_underflow` never asserts.
- Row-start gating: FIFO empty for 40 cycles after VBP, then filled -> `o_href` stays low and the first `o_rd` occurs in the first cycle with `i_empty`=0; `o_href` rises 2 cycles later.
- Mid-row underflow: FIFO holds 3 pixels, COLS=10 -> pixels 4..10 are sent as bytes 8'h00,8'h00; `o_underflow` pulses 7 times; `o_href` is high for exactly 20 cycles.
- Frame timing: default parameters, `i_en` held high -> `o_vsync` is high for 3 cycles, first `o_href` rises 19 cycles after vsync falls, consecutive `o_frame_done` pulses are one frame period apart.
- Reset mid-row: assert `i_rst` at byte 7 of row 2 -> next edge all outputs are 0 and state is IDLE; after release with `i_en`=1, a full fresh frame starts with VSYNC.
- With `DVP_TX_TESTPAT_EN`, `i_testpat`=1 -> row 2, col 3 bytes are 8'h02,8'h03; `o_rd` is never asserted.

Source files
------------

// File: rtl/dvp_pkg.sv
// Shared types and constants for the DVP transmitter.
package dvp_pkg;

  localparam int DVP_CNT_W = 16;

  localparam logic [3:0]  PAD_NIBBLE    = 4'h0;
  localparam logic [11:0] UNDERFLOW_PIX = 12'h000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_VSYNC,
    S_VBP,
    S_HBLANK,
    S_ROW,
    S_VFP
  } dvp_tx_state_t;

endpackage

// File: rtl/dvp_tx_timing.sv
// dvp_tx frame sequencer: state machine plus blank/row/byte counters.
// DVP_TX_TESTPAT_EN adds the pattern coordinate and vsync-entry outputs.
module dvp_tx_timing
  import dvp_pkg::*;
#(
  parameter int COLS      = 10,
  parameter int ROWS      = 5,
  parameter int VSYNC_LEN = 3,
  parameter int VBP       = 17,
  parameter int HBLANK    = 5,
  parameter int VFP       = 10
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_en,
  input  logic        go,
`ifdef DVP_TX_TESTPAT_EN
  output logic        vs_entry,
  output logic [11:0] pat,
`endif
  output logic        vsync_act,
  output logic        row_go,
  output logic        in_row,
  output logic        byte1,
  output logic        rd_due,
  output logic        eof
);

  localparam int CW = DVP_CNT_W;
  localparam logic [CW-1:0] L_VS   = CW'(VSYNC_LEN - 1);
  // gate opens one count late: outputs trail the sequencer by a cycle
  localparam logic [CW-1:0] L_VBP  = CW'(VBP + 1);
  localparam logic [CW-1:0] L_HB   = CW'(HBLANK + 1);
  localparam logic [CW-1:0] L_ROW  = CW'(2 * COLS - 1);
  localparam logic [CW-1:0] L_VFP  = CW'(VFP - 1);
  localparam logic [CW-1:0] L_EOF  = CW'(VFP - 2);
  localparam logic [CW-1:0] L_LAST = CW'(ROWS - 1);

  dvp_tx_state_t state, nxt;
  logic [CW-1:0] cnt, row;
  logic          gate;

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= S_IDLE;
    else       state <= nxt;
  end

  always_comb begin
    gate = (state == S_VBP    && cnt == L_VBP) ||
           (state == S_HBLANK && cnt == L_HB);
  end

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE:   if (i_en) nxt = S_VSYNC;
      S_VSYNC:  if (cnt == L_VS) nxt = S_VBP;
      S_VBP,
      S_HBLANK: if (gate && go) nxt = S_ROW;
      S_ROW:    if (cnt == L_ROW)
                  nxt = (row == L_LAST) ? S_VFP : S_HBLANK;
      S_VFP:    if (cnt == L_VFP)
                  nxt = i_en ? S_VSYNC : S_IDLE;
      default:  nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt <= '0;
      row <= '0;
    end else begin
      if (nxt != state)
        cnt <= '0;
      else if (state != S_IDLE && !gate)
        cnt <= cnt + 1'b1;
      if (nxt == S_VSYNC && state != S_VSYNC)
        row <= '0;
      else if (state == S_ROW && nxt == S_HBLANK)
        row <= row + 1'b1;
    end
  end

  always_comb begin
    vsync_act = (state == S_VSYNC);
    row_go    = gate && go;
    in_row    = (state == S_ROW);
    byte1     = in_row && cnt[0];
    rd_due    = byte1 && (cnt != L_ROW);
    eof       = (state == S_VFP) && (cnt == L_EOF);
`ifdef DVP_TX_TESTPAT_EN
    vs_entry  = (nxt == S_VSYNC) && (state != S_VSYNC);
    pat       = {row[3:0], cnt[8:1]};
`endif
  end

endmodule

// File: rtl/dvp_tx.sv
// DVP transmitter: FIFO pixels out as two-byte RGB444 on vsync/href.
// DVP_TX_TESTPAT_EN adds i_testpat and the internal coordinate pattern.
module dvp_tx
  import dvp_pkg::*;
#(
  parameter int COLS      = 10,
  parameter int ROWS      = 5,
  parameter int VSYNC_LEN = 3,
  parameter int VBP       = 17,
  parameter int HBLANK    = 5,
  parameter int VFP       = 10
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_en,
`ifdef DVP_TX_TESTPAT_EN
  input  logic        i_testpat,
`endif
  output logic        o_rd,
  input  logic [11:0] i_rdata,
  input  logic        i_empty,
  output logic        o_vsync,
  output logic        o_href,
  output logic [7:0]  o_data,
  output logic        o_underflow,
  output logic        o_frame_done
);

  logic        vsync_act, row_go, in_row, byte1, rd_due, eof;
  logic        tp, go, miss;
  logic [7:0]  pix_lo;
  logic [11:0] pix_n;

`ifdef DVP_TX_TESTPAT_EN
  logic        vs_entry;
  logic [11:0] pat;

  always_ff @(posedge i_clk) begin
    if (i_rst)         tp <= 1'b0;
    else if (vs_entry) tp <= i_testpat;
  end
`else
  assign tp = 1'b0;
`endif

  assign go = tp || !i_empty;

  dvp_tx_timing #(
    .COLS(COLS), .ROWS(ROWS), .VSYNC_LEN(VSYNC_LEN),
    .VBP(VBP), .HBLANK(HBLANK), .VFP(VFP)
  ) u_tim (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .i_en(i_en),
    .go(go),
`ifdef DVP_TX_TESTPAT_EN
    .vs_entry(vs_entry),
    .pat(pat),
`endif
    .vsync_act(vsync_act),
    .row_go(row_go),
    .in_row(in_row),
    .byte1(byte1),
    .rd_due(rd_due),
    .eof(eof)
  );

  // empty gates the strobe in the same cycle so a dry FIFO is never read
  assign o_rd = !i_rst && !tp &&
                (row_go || (rd_due && !i_empty));

  always_comb begin
    pix_n = i_rdata;
    if (miss) pix_n = UNDERFLOW_PIX;
`ifdef DVP_TX_TESTPAT_EN
    if (tp) pix_n = pat;
`endif
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_vsync      <= 1'b0;
      o_href       <= 1'b0;
      o_data       <= '0;
      o_underflow  <= 1'b0;
      o_frame_done <= 1'b0;
      miss         <= 1'b0;
      pix_lo       <= '0;
    end else begin
      o_vsync      <= vsync_act;
      o_frame_done <= eof;
      miss         <= !tp && rd_due && i_empty;
      unique case (1'b1)
        (in_row && !byte1): begin
          o_href      <= 1'b1;
          o_data      <= {PAD_NIBBLE, pix_n[11:8]};
          o_underflow <= miss;
          pix_lo      <= pix_n[7:0];
        end
        byte1: begin
          o_href      <= 1'b1;
          o_data      <= pix_lo;
          o_underflow <= 1'b0;
        end
        default: begin
          o_href      <= 1'b0;
          o_data      <= '0;
          o_underflow <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dvp_tx.sv
// Directed bench for dvp_tx: FIFO model, output monitor, per-scenario tasks.
module tb_dvp_tx;
  import dvp_pkg::*;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_en  = 1'b0;
  logic        o_rd;
  logic [11:0] i_rdata = '0;
  logic        i_empty;
  logic        o_vsync, o_href, o_underflow, o_frame_done;
  logic [7:0]  o_data;
`ifdef DVP_TX_TESTPAT_EN
  logic        i_testpat = 1'b0;
`endif

  int errs = 0;
  int checks = 0;

  logic [11:0] mem [0:1023];
  int          wp = 0;
  int          rp = 0;
  logic [11:0] exp_q [$];

  int          cyc = 0;
  int          n_rd = 0;
  int          n_uf = 0;
  logic [7:0]  hb [$];
  int          rd_t [$];
  int          hr_t [$];
  int          hf_t [$];
  int          vr_t [$];
  int          vf_t [$];
  int          fd_t [$];
  logic        ph = 1'b0;
  logic        pv = 1'b0;

  always #5 i_clk = ~i_clk;

  dvp_tx dut (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .i_en(i_en),
`ifdef DVP_TX_TESTPAT_EN
    .i_testpat(i_testpat),
`endif
    .o_rd(o_rd),
    .i_rdata(i_rdata),
    .i_empty(i_empty),
    .o_vsync(o_vsync),
    .o_href(o_href),
    .o_data(o_data),
    .o_underflow(o_underflow),
    .o_frame_done(o_frame_done)
  );

  assign i_empty = (wp == rp);

  always @(posedge i_clk) begin
    if (o_rd) begin
      i_rdata <= mem[rp[9:0]];
      rp      <= rp + 1;
    end
  end

  always @(negedge i_clk) begin
    #1;
    cyc = cyc + 1;
    if (o_rd === 1'b1) begin
      n_rd = n_rd + 1;
      rd_t.push_back(cyc);
    end
    if (o_underflow === 1'b1) n_uf = n_uf + 1;
    if (o_href === 1'b1) hb.push_back(o_data);
    if (o_href === 1'b1 && !ph) hr_t.push_back(cyc);
    if (o_href === 1'b0 && ph) hf_t.push_back(cyc);
    if (o_vsync === 1'b1 && !pv) vr_t.push_back(cyc);
    if (o_vsync === 1'b0 && pv) vf_t.push_back(cyc);
    if (o_frame_done === 1'b1) fd_t.push_back(cyc);
    ph = (o_href === 1'b1);
    pv = (o_vsync === 1'b1);
  end

  task automatic push(input logic [11:0] x);
    mem[wp[9:0]] = x;
    wp = wp + 1;
    exp_q.push_back(x);
  endtask

  task automatic flush();
    wp = rp;
    exp_q.delete();
  endtask

  task automatic wait_fd(input int n, input string nm);
    for (int i = 0; i < 600 && fd_t.size() < n; i++)
      @(negedge i_clk);
    checks++;
    if (fd_t.size() < n) begin
      errs++;
      $display("FAIL %s timeout: frame_done count %0d want %0d",
               nm, fd_t.size(), n);
    end
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    i_en  = 1'b0;
    repeat (3) @(negedge i_clk);
    #2;
    checks += 6;
    if (o_vsync !== 1'b0) begin errs++; $display("FAIL rst_vsync got %b want 0", o_vsync); end
    if (o_href !== 1'b0) begin errs++; $display("FAIL rst_href got %b want 0", o_href); end
    if (o_data !== 8'h00) begin errs++; $display("FAIL rst_data got %h want 00", o_data); end
    if (o_rd !== 1'b0) begin errs++; $display("FAIL rst_rd got %b want 0", o_rd); end
    if (o_underflow !== 1'b0) begin errs++; $display("FAIL rst_uf got %b want 0", o_underflow); end
    if (o_frame_done !== 1'b0) begin errs++; $display("FAIL rst_fd got %b want 0", o_frame_done); end
    @(negedge i_clk);
    i_rst = 1'b0;
    repeat (4) @(negedge i_clk);
    #2;
    checks++;
    if (o_vsync !== 1'b0) begin errs++; $display("FAIL idle_vsync got %b want 0", o_vsync); end
  endtask

  task automatic test_frame_timing();
    int b0, r0, u0, vr0, vf0, hr0, fd0, bad;
    flush();
    for (int k = 0; k < 100; k++) push(12'($urandom_range(4095, 0)));
    b0 = hb.size(); r0 = n_rd; u0 = n_uf;
    vr0 = vr_t.size(); vf0 = vf_t.size(); hr0 = hr_t.size(); fd0 = fd_t.size();
    @(negedge i_clk);
    i_en = 1'b1;
    wait_fd(fd0 + 1, "frame1");
    i_en = 1'b0;
    wait_fd(fd0 + 2, "frame2");
    repeat (30) @(negedge i_clk);
    #2;
    checks += 8;
    if (vf_t[vf0] - vr_t[vr0] != 3) begin
      errs++; $display("FAIL vsync_width got %0d want 3", vf_t[vf0] - vr_t[vr0]);
    end
    if (hr_t[hr0] - vf_t[vf0] != 19) begin
      errs++; $display("FAIL vbp_to_href got %0d want 19", hr_t[hr0] - vf_t[vf0]);
    end
    if (fd_t[fd0 + 1] - fd_t[fd0] != 160) begin
      errs++; $display("FAIL frame_period got %0d want 160", fd_t[fd0 + 1] - fd_t[fd0]);
    end
    if (hr_t[hr0 + 1] - hr_t[hr0] != 27) begin
      errs++; $display("FAIL row_period got %0d want 27", hr_t[hr0 + 1] - hr_t[hr0]);
    end
    if (n_rd - r0 != 100) begin
      errs++; $display("FAIL loop_reads got %0d want 100", n_rd - r0);
    end
    if (n_uf - u0 != 0) begin
      errs++; $display("FAIL loop_uf got %0d want 0", n_uf - u0);
    end
    if (hb.size() - b0 != 200) begin
      errs++; $display("FAIL loop_bytes got %0d want 200", hb.size() - b0);
    end
    if (vr_t.size() - vr0 != 2) begin
      errs++; $display("FAIL en_low_frames got %0d want 2", vr_t.size() - vr0);
    end
    bad = 0;
    for (int k = 0; k < 100; k++) begin
      checks++;
      if (hb[b0 + 2*k] !== {4'h0, exp_q[k][11:8]} ||
          hb[b0 + 2*k + 1] !== exp_q[k][7:0]) begin
        errs++; bad++;
        if (bad < 5)
          $display("FAIL loop_pix%0d got %h%h want %h", k,
                   hb[b0 + 2*k], hb[b0 + 2*k + 1], exp_q[k]);
      end
    end
  endtask

  task automatic test_row_gating();
    int b0, r0, u0, vf0, hr0, fd0, rdi, viol, bad;
    flush();
    b0 = hb.size(); r0 = n_rd; u0 = n_uf;
    vf0 = vf_t.size(); hr0 = hr_t.size(); fd0 = fd_t.size();
    @(negedge i_clk);
    i_en = 1'b1;
    @(negedge i_clk);
    i_en = 1'b0;
    for (int i = 0; i < 60 && vf_t.size() <= vf0; i++)
      @(negedge i_clk);
    checks++;
    if (vf_t.size() <= vf0) begin
      errs++; $display("FAIL gate_vsync timeout got %0d want %0d", vf_t.size(), vf0 + 1);
    end
    viol = 0;
    for (int i = 0; i < 56; i++) begin
      #2;
      if (o_rd !== 1'b0 || o_href !== 1'b0) viol++;
      @(negedge i_clk);
    end
    checks++;
    if (viol != 0) begin
      errs++; $display("FAIL gate_idle got %0d active cycles want 0", viol);
    end
    rdi = rd_t.size();
    for (int k = 0; k < 50; k++) push(12'($urandom_range(4095, 0)));
    #2;
    checks++;
    if (o_rd !== 1'b1) begin
      errs++; $display("FAIL gate_first_rd got %b want 1", o_rd);
    end
    wait_fd(fd0 + 1, "gate_frame");
    #2;
    checks += 4;
    if (hr_t[hr0] - rd_t[rdi] != 2) begin
      errs++; $display("FAIL gate_href_lat got %0d want 2", hr_t[hr0] - rd_t[rdi]);
    end
    if (n_rd - r0 != 50) begin
      errs++; $display("FAIL gate_reads got %0d want 50", n_rd - r0);
    end
    if (n_uf - u0 != 0) begin
      errs++; $display("FAIL gate_uf got %0d want 0", n_uf - u0);
    end
    if (hb.size() - b0 != 100) begin
      errs++; $display("FAIL gate_bytes got %0d want 100", hb.size() - b0);
    end
    bad = 0;
    for (int k = 0; k < 50; k++)
      if (hb[b0 + 2*k] !== {4'h0, exp_q[k][11:8]} ||
          hb[b0 + 2*k + 1] !== exp_q[k][7:0]) bad++;
    checks++;
    if (bad != 0) begin
      errs++; $display("FAIL gate_data got %0d bad pixels want 0", bad);
    end
  endtask

  task automatic test_underflow();
    int b0, r0, u0, hr0, hf0, fd0, bad, nz;
    flush();
    b0 = hb.size(); r0 = n_rd; u0 = n_uf;
    hr0 = hr_t.size(); hf0 = hf_t.size(); fd0 = fd_t.size();
    push(12'hA5C); push(12'h3F1); push(12'h7E2);
    @(negedge i_clk);
    i_en = 1'b1;
    @(negedge i_clk);
    i_en = 1'b0;
    for (int i = 0; i < 200 && hf_t.size() <= hf0; i++)
      @(negedge i_clk);
    #2;
    checks += 4;
    if (hf_t[hf0] - hr_t[hr0] != 20) begin
      errs++; $display("FAIL uf_href_len got %0d want 20", hf_t[hf0] - hr_t[hr0]);
    end
    if (n_uf - u0 != 7) begin
      errs++; $display("FAIL uf_pulses got %0d want 7", n_uf - u0);
    end
    if (n_rd - r0 != 3) begin
      errs++; $display("FAIL uf_reads got %0d want 3", n_rd - r0);
    end
    bad = 0;
    for (int k = 0; k < 3; k++)
      if (hb[b0 + 2*k] !== {4'h0, exp_q[k][11:8]} ||
          hb[b0 + 2*k + 1] !== exp_q[k][7:0]) bad++;
    if (bad != 0) begin
      errs++; $display("FAIL uf_head got %0d bad pixels want 0", bad);
    end
    nz = 0;
    for (int k = 6; k < 20; k++)
      if (hb[b0 + k] !== 8'h00) nz++;
    checks++;
    if (nz != 0) begin
      errs++; $display("FAIL uf_zero got %0d nonzero bytes want 0", nz);
    end
    for (int k = 0; k < 40; k++) push(12'($urandom_range(4095, 0)));
    wait_fd(fd0 + 1, "uf_frame");
    #2;
    checks += 2;
    if (n_uf - u0 != 7) begin
      errs++; $display("FAIL uf_total got %0d want 7", n_uf - u0);
    end
    bad = 0;
    for (int k = 0; k < 40; k++)
      if (hb[b0 + 20 + 2*k] !== {4'h0, exp_q[3 + k][11:8]} ||
          hb[b0 + 21 + 2*k] !== exp_q[3 + k][7:0]) bad++;
    if (bad != 0) begin
      errs++; $display("FAIL uf_tail got %0d bad pixels want 0", bad);
    end
  endtask

  task automatic test_reset_mid_row();
    int hr0, vr0, vf0, fd0, b0, u0, rel, bad;
    flush();
    for (int k = 0; k < 100; k++) push(12'($urandom_range(4095, 0)));
    hr0 = hr_t.size();
    @(negedge i_clk);
    i_en = 1'b1;
    for (int i = 0; i < 300 && hr_t.size() < hr0 + 3; i++)
      @(negedge i_clk);
    repeat (5) @(negedge i_clk);
    i_rst = 1'b1;
    @(negedge i_clk);
    #2;
    checks += 7;
    if (o_vsync !== 1'b0) begin errs++; $display("FAIL mid_vsync got %b want 0", o_vsync); end
    if (o_href !== 1'b0) begin errs++; $display("FAIL mid_href got %b want 0", o_href); end
    if (o_data !== 8'h00) begin errs++; $display("FAIL mid_data got %h want 00", o_data); end
    if (o_rd !== 1'b0) begin errs++; $display("FAIL mid_rd got %b want 0", o_rd); end
    if (o_underflow !== 1'b0) begin errs++; $display("FAIL mid_uf got %b want 0", o_underflow); end
    if (o_frame_done !== 1'b0) begin errs++; $display("FAIL mid_fd got %b want 0", o_frame_done); end
    if (dut.u_tim.state !== S_IDLE) begin
      errs++; $display("FAIL mid_state got %0d want %0d", dut.u_tim.state, S_IDLE);
    end
    flush();
    for (int k = 0; k < 50; k++) push(12'($urandom_range(4095, 0)));
    b0 = hb.size(); u0 = n_uf;
    vr0 = vr_t.size(); vf0 = vf_t.size(); fd0 = fd_t.size();
    @(negedge i_clk);
    i_rst = 1'b0;
    rel = cyc + 1;
    for (int i = 0; i < 10 && vr_t.size() <= vr0; i++)
      @(negedge i_clk);
    i_en = 1'b0;
    wait_fd(fd0 + 1, "fresh_frame");
    #2;
    checks += 4;
    if (vr_t[vr0] != rel + 2) begin
      errs++; $display("FAIL fresh_vsync_at got %0d want %0d", vr_t[vr0], rel + 2);
    end
    if (vf_t[vf0] - vr_t[vr0] != 3) begin
      errs++; $display("FAIL fresh_vsync_w got %0d want 3", vf_t[vf0] - vr_t[vr0]);
    end
    if (n_uf - u0 != 0) begin
      errs++; $display("FAIL fresh_uf got %0d want 0", n_uf - u0);
    end
    bad = 0;
    for (int k = 0; k < 50; k++)
      if (hb[b0 + 2*k] !== {4'h0, exp_q[k][11:8]} ||
          hb[b0 + 2*k + 1] !== exp_q[k][7:0]) bad++;
    if (bad != 0) begin
      errs++; $display("FAIL fresh_data got %0d bad pixels want 0", bad);
    end
  endtask

`ifdef DVP_TX_TESTPAT_EN
  task automatic test_testpat();
    int b0, r0, fd0;
    flush();
    b0 = hb.size(); r0 = n_rd; fd0 = fd_t.size();
    i_testpat = 1'b1;
    @(negedge i_clk);
    i_en = 1'b1;
    @(negedge i_clk);
    i_en = 1'b0;
    i_testpat = 1'b0;
    wait_fd(fd0 + 1, "tp_frame");
    #2;
    checks += 3;
    if (hb[b0 + 46] !== 8'h02 || hb[b0 + 47] !== 8'h03) begin
      errs++; $display("FAIL tp_r2c3 got %h%h want 0203", hb[b0 + 46], hb[b0 + 47]);
    end
    if (hb[b0 + 20] !== 8'h01 || hb[b0 + 39] !== 8'h09) begin
      errs++; $display("FAIL tp_r1 got %h/%h want 01/09", hb[b0 + 20], hb[b0 + 39]);
    end
    if (n_rd - r0 != 0) begin
      errs++; $display("FAIL tp_reads got %0d want 0", n_rd - r0);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_frame_timing();
    test_row_gating();
    test_underflow();
    test_reset_mid_row();
`ifdef DVP_TX_TESTPAT_EN
    test_testpat();
`endif
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
